// File: rtl/mul_eval_pkg.sv
// Shared types and sizes for the approximate-multiplier error sweep.
// Widths here describe the default 8-bit operand configuration.
package mul_eval_pkg;

    localparam int OP_W     = 8;
    localparam int P_W      = 2 * OP_W;
    localparam int PAIRS    = 1 << P_W;
    localparam int SUMABS_W = 4 * OP_W;
    localparam int CNT_W    = 2 * OP_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/mul_err_calc.sv
// Combinational error terms for one operand pair: exact product,
// absolute error of the approximate product, and its square.
module mul_err_calc
    import mul_eval_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [2*W-1:0] approx_i,
    output logic [2*W-1:0] abs_err_o,
    output logic [4*W-1:0] sq_err_o
);

    logic [2*W-1:0] exact;

    // |approx - exact| always fits in 2W bits, so the ordered subtraction is exact.
    always_comb begin
        exact     = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
        abs_err_o = (approx_i >= exact) ? (approx_i - exact) : (exact - approx_i);
        sq_err_o  = {{(2*W){1'b0}}, abs_err_o} * {{(2*W){1'b0}}, abs_err_o};
    end

endmodule

// File: rtl/mul8u_err_sweep.sv
// Exhaustive sweep controller: walks every operand pair through an external
// approximate multiplier and accumulates MAE/MSE/WCE/EP statistics.
module mul8u_err_sweep
    import mul_eval_pkg::*;
#(
    parameter int W    = OP_W,
    parameter int SQ_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   approx_o,
    output logic             busy,
    output logic             done,
    output logic [4*W-1:0]   sum_abs_err,
    output logic [SQ_W-1:0]  sum_sq_err,
    output logic [2*W:0]     err_count,
    output logic [2*W-1:0]   wce,
    output logic [W-1:0]     wce_a,
    output logic [W-1:0]     wce_b
);

    state_e           state_q, state_d;
    logic [2*W-1:0]   idx_q, idx_d;
    logic             done_q, done_d;
    logic             v1_q, v1_d;
    logic             sample, clear;

    logic [2*W-1:0]   abs_w;
    logic [4*W-1:0]   sq_w;
    logic [2*W-1:0]   abs1_q;
    logic [4*W-1:0]   sq1_q;
    logic [W-1:0]     a1_q, b1_q;

    logic [4*W-1:0]   sum_abs_q, sum_abs_d;
    logic [SQ_W-1:0]  sum_sq_q, sum_sq_d;
    logic [2*W:0]     cnt_q, cnt_d;
    logic [2*W-1:0]   wce_q, wce_d;
    logic [W-1:0]     wce_a_q, wce_a_d, wce_b_q, wce_b_d;

    assign op_a = idx_q[2*W-1:W];
    assign op_b = idx_q[W-1:0];

    mul_err_calc #(.W(W)) u_calc (
        .a_i       (op_a),
        .b_i       (op_b),
        .approx_i  (approx_o),
        .abs_err_o (abs_w),
        .sq_err_o  (sq_w)
    );

    assign sample = (state_q == SWEEP) && !abort && !pause;
    assign clear  = start && !abort && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        v1_d    = sample;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else if (!pause) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == {(2*W){1'b1}}) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else if (clear) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 2: fold the registered stage-1 error into the running statistics.
    always_comb begin
        sum_abs_d = sum_abs_q;
        sum_sq_d  = sum_sq_q;
        cnt_d     = cnt_q;
        wce_d     = wce_q;
        wce_a_d   = wce_a_q;
        wce_b_d   = wce_b_q;
        if (clear) begin
            sum_abs_d = '0;
            sum_sq_d  = '0;
            cnt_d     = '0;
            wce_d     = '0;
            wce_a_d   = '0;
            wce_b_d   = '0;
        end else if (v1_q) begin
            sum_abs_d = sum_abs_q + {{(2*W){1'b0}}, abs1_q};
            sum_sq_d  = sum_sq_q + {{(SQ_W-4*W){1'b0}}, sq1_q};
            cnt_d     = cnt_q + {{(2*W){1'b0}}, (abs1_q != '0)};
            if (abs1_q > wce_q) begin
                wce_d   = abs1_q;
                wce_a_d = a1_q;
                wce_b_d = b1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            done_q    <= 1'b0;
            v1_q      <= 1'b0;
            sum_abs_q <= '0;
            sum_sq_q  <= '0;
            cnt_q     <= '0;
            wce_q     <= '0;
            wce_a_q   <= '0;
            wce_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            v1_q      <= v1_d;
            sum_abs_q <= sum_abs_d;
            sum_sq_q  <= sum_sq_d;
            cnt_q     <= cnt_d;
            wce_q     <= wce_d;
            wce_a_q   <= wce_a_d;
            wce_b_q   <= wce_b_d;
        end
    end

    // Stage 1: capture the current pair's error terms.
    always_ff @(posedge clk) begin
        if (sample) begin
            abs1_q <= abs_w;
            sq1_q  <= sq_w;
            a1_q   <= op_a;
            b1_q   <= op_b;
        end
    end

    assign busy        = (state_q == SWEEP) || (state_q == DRAIN);
    assign done        = done_q;
    assign sum_abs_err = sum_abs_q;
    assign sum_sq_err  = sum_sq_q;
    assign err_count   = cnt_q;
    assign wce         = wce_q;
    assign wce_a       = wce_a_q;
    assign wce_b       = wce_b_q;

endmodule

// File: tb/tb_mul8u_err_sweep.sv
// Bench for mul8u_err_sweep, run at W=4 (256 pairs) so each sweep is short.
module tb_mul8u_err_sweep;

    localparam int TW  = 4;
    localparam int TSQ = 24;
    localparam int PW  = 2 * TW;

    logic              clk = 1'b0;
    logic              rst, start, abort, pause;
    logic [TW-1:0]     op_a, op_b;
    logic [PW-1:0]     approx_o;
    logic              busy, done;
    logic [4*TW-1:0]   sum_abs_err;
    logic [TSQ-1:0]    sum_sq_err;
    logic [PW:0]       err_count;
    logic [PW-1:0]     wce;
    logic [TW-1:0]     wce_a, wce_b;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int edges  = 0;

    typedef struct {
        string           name;
        logic [4*TW-1:0] sa;
        logic [TSQ-1:0]  sq;
        logic [PW:0]     cnt;
        logic [PW-1:0]   wce;
        logic [TW-1:0]   wa;
        logic [TW-1:0]   wb;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul8u_err_sweep #(.W(TW), .SQ_W(TSQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .op_a        (op_a),
        .op_b        (op_b),
        .approx_o    (approx_o),
        .busy        (busy),
        .done        (done),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .err_count   (err_count),
        .wce         (wce),
        .wce_a       (wce_a),
        .wce_b       (wce_b)
    );

    // Approximate-multiplier stubs
    logic [PW-1:0] exact_stub;
    always_comb begin
        exact_stub = {{TW{1'b0}}, op_a} * {{TW{1'b0}}, op_b};
        approx_o   = exact_stub;
        case (mode)
            1:       approx_o = '0;
            2:       approx_o = exact_stub + 1'b1;
            3:       approx_o = (exact_stub == '0) ? '0 : exact_stub - 1'b1;
            default: approx_o = exact_stub;
        endcase
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input string n, input int sa, input int sq, input int cnt,
                                input int w, input int wa, input int wb);
        exp_t e;
        e.name = n;
        e.sa   = sa[4*TW-1:0];
        e.sq   = sq[TSQ-1:0];
        e.cnt  = cnt[PW:0];
        e.wce  = w[PW-1:0];
        e.wa   = wa[TW-1:0];
        e.wb   = wb[TW-1:0];
        return e;
    endfunction

    // Monitor: each rising done pops one expected result set.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done actual=1 required=0");
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_sum_abs"}, sum_abs_err, e.sa);
                chk({e.name, "_sum_sq"},  sum_sq_err,  e.sq);
                chk({e.name, "_count"},   err_count,   e.cnt);
                chk({e.name, "_wce"},     wce,         e.wce);
                chk({e.name, "_wce_a"},   wce_a,       e.wa);
                chk({e.name, "_wce_b"},   wce_b,       e.wb);
            end
        end
        done_prev <= done;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        edges++;
    endtask

    task automatic issue_start(input int m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
    endtask

    task automatic start_run(input int m, input exp_t e);
        sb_q.push_back(e);
        issue_start(m);
    endtask

    task automatic wait_done(input string nm, input int req);
        while (done !== 1'b1 && edges < 2000) step();
        chk({nm, "_latency"}, edges, req);
        chk({nm, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {op_a, op_b, busy, done}, '0);
        chk({tag, "_acc"}, {sum_abs_err, sum_sq_err, err_count}, '0);
        chk({tag, "_wce"}, {wce, wce_a, wce_b}, '0);
    endtask

    logic [PW-1:0] held;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        // 16x16 pairs: sum a = 120, sum a^2 = 1240
        start_run(0, mk("exact", 0, 0, 0, 0, 0, 0));
        wait_done("exact", 257);
        start_run(1, mk("zero", 14400, 1537600, 225, 225, 15, 15));
        wait_done("zero", 257);
        start_run(2, mk("plus1", 256, 256, 256, 1, 0, 0));
        wait_done("plus1", 257);
        start_run(3, mk("minus1", 225, 225, 225, 1, 1, 1));
        wait_done("minus1", 257);

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_state", {busy, done}, 2'b00);
        chk("abort_done_retain", sum_abs_err, 225);

        start_run(1, mk("paused", 14400, 1537600, 225, 225, 15, 15));
        repeat (40) step();
        pause = 1'b1;
        held = {op_a, op_b};
        chk("pause_idx", held, 40);
        repeat (20) step();
        chk("pause_op_hold", {op_a, op_b}, held);
        chk("pause_busy", busy, 1'b1);
        pause = 1'b0;
        wait_done("paused", 277);

        issue_start(2);
        repeat (30) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_sweep", {busy, done}, 2'b00);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_over_start", busy, 1'b0);
        start_run(2, mk("after_abort", 256, 256, 256, 1, 0, 0));
        wait_done("after_abort", 257);

        issue_start(1);
        repeat (20) step();
        held = {op_a, op_b};
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored", {op_a, op_b}, held + 1'b1);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_reset");
        repeat (3) step();
        chk("idle_after_reset", {op_a, op_b, busy}, '0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
